// File: rtl/logic_thief_capture_ctrl_if.sv
// Bus bundle between the software command/config registers, the capture sequencer and the trace BRAM write port.
// When LOGTHIEF_TRIG_OCCUR_EN is defined, it also carries the trigger occurrence count.
interface logic_thief_capture_ctrl_if #(
  parameter int LOG2_DEEP   = 8,
  parameter int MATCH_WIDTH = 8
);
  logic [31:0]          cmd_i;
  logic [MATCH_WIDTH-1:0] trig_data_i;
  logic [MATCH_WIDTH-1:0] trig_mask_i;
  logic [MATCH_WIDTH-1:0] trig_value_i;
  logic [LOG2_DEEP-1:0]   post_count_i;
`ifdef LOGTHIEF_TRIG_OCCUR_EN
  logic [7:0]             occur_count_i;
`endif
  logic [LOG2_DEEP-1:0]   wr_addr_o;
  logic                   wr_en_o;
  logic [1:0]             state_o;
  logic [LOG2_DEEP-1:0]   trig_addr_o;
  logic                   wrapped_o;
  logic                   done_o;

  modport master (
    output cmd_i, trig_data_i, trig_mask_i, trig_value_i, post_count_i,
`ifdef LOGTHIEF_TRIG_OCCUR_EN
    output occur_count_i,
`endif
    input  wr_addr_o, wr_en_o, state_o, trig_addr_o, wrapped_o, done_o
  );

  modport slave (
    input  cmd_i, trig_data_i, trig_mask_i, trig_value_i, post_count_i,
`ifdef LOGTHIEF_TRIG_OCCUR_EN
    input  occur_count_i,
`endif
    output wr_addr_o, wr_en_o, state_o, trig_addr_o, wrapped_o, done_o
  );
endinterface

// File: rtl/logic_thief_capture_ctrl.sv
// Trigger/capture sequencer for the logic-thief trace BRAM. It records into a circular buffer, triggers on a masked match,
// writes post-trigger samples and then freezes. Optional feature macro: LOGTHIEF_TRIG_OCCUR_EN (fire on the Nth match).
module logic_thief_capture_ctrl #(
  parameter int          LOG2_DEEP   = 8,
  parameter int          MATCH_WIDTH = 8,
  parameter logic [31:0] CMD_CLEAR   = 32'hDEADDEAD,
  parameter logic [31:0] CMD_ARM     = 32'hDEADCAFE
) (
  input  logic clk_i,
  input  logic rst_i,
  logic_thief_capture_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    POST  = 2'b10,
    DONE  = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          cmd_q;
  logic [LOG2_DEEP-1:0] wr_addr_q, wr_addr_d;
  logic [LOG2_DEEP-1:0] trig_addr_q, trig_addr_d;
  logic [LOG2_DEEP-1:0] remaining_q, remaining_d;
  logic                 wrapped_q, wrapped_d;
  logic [7:0]           occur_q, occur_d;

  logic wr_en;
  logic arm_evt;
  logic match;
  logic fire;

  assign wr_en   = (state_q == ARMED) || (state_q == POST);
  assign arm_evt = (bus.cmd_i == CMD_ARM) && (cmd_q != CMD_ARM);
  assign match   = ((bus.trig_data_i ^ bus.trig_value_i) & bus.trig_mask_i) == '0;

`ifdef LOGTHIEF_TRIG_OCCUR_EN
  assign fire = match && (occur_q == bus.occur_count_i);
`else
  assign fire = match;
`endif

  // NOTE: every next-state signal is given its hold value first, so no path through this block can infer a latch.
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    trig_addr_d = trig_addr_q;
    remaining_d = remaining_q;
    wrapped_d   = wrapped_q;
    occur_d     = occur_q;

    // Every write slot advances the circular address, whatever the state.
    if (wr_en) begin
      wr_addr_d = wr_addr_q + LOG2_DEEP'(1);
      if (&wr_addr_q) wrapped_d = 1'b1;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (arm_evt) begin
          state_d     = ARMED;
          wr_addr_d   = '0;
          trig_addr_d = '0;
          wrapped_d   = 1'b0;
          occur_d     = '0;
        end
      end
      ARMED: begin
        if (fire) begin
          trig_addr_d = wr_addr_q;
          remaining_d = bus.post_count_i;
          state_d     = (bus.post_count_i == '0) ? DONE : POST;
        end else if (match) begin
          occur_d = occur_q + 8'd1;
        end
      end
      POST: begin
        remaining_d = remaining_q - LOG2_DEEP'(1);
        if (remaining_q == LOG2_DEEP'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (bus.cmd_i == CMD_CLEAR) begin
      state_d     = IDLE;
      wr_addr_d   = '0;
      trig_addr_d = '0;
      remaining_d = '0;
      wrapped_d   = 1'b0;
      occur_d     = '0;
    end
  end

  // NOTE: registers use non-blocking assignments so all flops sample their inputs from the same clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
      remaining_q <= '0;
      wrapped_q   <= 1'b0;
      occur_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= bus.cmd_i;
      wr_addr_q   <= wr_addr_d;
      trig_addr_q <= trig_addr_d;
      remaining_q <= remaining_d;
      wrapped_q   <= wrapped_d;
      occur_q     <= occur_d;
    end
  end

  assign bus.wr_addr_o   = wr_addr_q;
  assign bus.wr_en_o     = wr_en;
  assign bus.state_o     = state_q;
  assign bus.trig_addr_o = trig_addr_q;
  assign bus.wrapped_o   = wrapped_q;
  assign bus.done_o      = (state_q == DONE);

endmodule

// File: tb/tb_logic_thief_capture_ctrl.sv
// Self-checking bench for logic_thief_capture_ctrl. It runs directed scenarios and then randomized traffic, all
// checked against a transaction-level model that counts writes since arm.
module tb_logic_thief_capture_ctrl;
  localparam int          LOG2_DEEP = 8;
  localparam int          DEPTH     = 1 << LOG2_DEEP;
  localparam logic [31:0] CLR       = 32'hDEADDEAD;
  localparam logic [31:0] ARM       = 32'hDEADCAFE;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic_thief_capture_ctrl_if #(.LOG2_DEEP(LOG2_DEEP), .MATCH_WIDTH(8)) bus ();

  logic_thief_capture_ctrl #(.LOG2_DEEP(LOG2_DEEP), .MATCH_WIDTH(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a mode plus the number of samples written since arm.
  // mode 0 = idle, 1 = waiting for the trigger, 2 = post-trigger, 3 = frozen.
  int          m_mode;
  int          m_writes;
  int          m_trig;
  int          m_left;
  int          m_hits;
  logic [31:0] m_last_cmd;

  function automatic int occur_cfg();
`ifdef LOGTHIEF_TRIG_OCCUR_EN
    return int'(bus.occur_count_i);
`else
    return 0;
`endif
  endfunction

  task automatic model_step();
    bit arm;
    bit hit;
    arm = (bus.cmd_i == ARM) && (m_last_cmd != ARM);
    hit = ((bus.trig_data_i ^ bus.trig_value_i) & bus.trig_mask_i) == 8'h00;
    if (rst || bus.cmd_i == CLR) begin
      m_mode = 0; m_writes = 0; m_trig = 0; m_left = 0; m_hits = 0;
    end else begin
      case (m_mode)
        0, 3: if (arm) begin
          m_mode = 1; m_writes = 0; m_trig = 0; m_hits = 0;
        end
        1: begin
          if (hit && m_hits == occur_cfg()) begin
            m_trig = m_writes % DEPTH;
            m_left = int'(bus.post_count_i);
            m_mode = (m_left == 0) ? 3 : 2;
          end else if (hit) begin
            m_hits++;
          end
          m_writes++;
        end
        default: begin
          m_writes++;
          m_left--;
          if (m_left == 0) m_mode = 3;
        end
      endcase
    end
    m_last_cmd = rst ? 32'h0 : bus.cmd_i;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state",   32'(bus.state_o),     32'(m_mode));
    check("wr_en",   32'(bus.wr_en_o),     32'(m_mode == 1 || m_mode == 2));
    check("wr_addr", 32'(bus.wr_addr_o),   32'(m_writes % DEPTH));
    check("trig",    32'(bus.trig_addr_o), 32'(m_trig));
    check("wrapped", 32'(bus.wrapped_o),   32'(m_writes >= DEPTH));
    check("done",    32'(bus.done_o),      32'(m_mode == 3));
  endtask

  // One clock: predict from the inputs driven now, then compare just after the edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic rearm();
    bus.cmd_i = 32'h0; cyc();
    bus.cmd_i = ARM;   cyc();
  endtask

  initial begin
    int pick;
    m_mode = 0; m_writes = 0; m_trig = 0; m_left = 0; m_hits = 0; m_last_cmd = '0;
    rst = 1'b1;
    bus.cmd_i = 32'h0; bus.trig_data_i = 8'h00; bus.trig_mask_i = 8'hFF;
    bus.trig_value_i = 8'hFF; bus.post_count_i = 8'd4;
`ifdef LOGTHIEF_TRIG_OCCUR_EN
    bus.occur_count_i = 8'd0;
`endif
    cyc(); cyc();
    check("reset_state", 32'(bus.state_o), 32'h0);
    rst = 1'b0;

    // Trigger at address 10 with four post samples.
    bus.cmd_i = ARM; cyc();
    repeat (10) cyc();
    bus.trig_data_i = 8'hFF; cyc();
    bus.trig_data_i = 8'h00;
    repeat (4) cyc();
    check("t1_trig_addr", 32'(bus.trig_addr_o), 32'd10);
    check("t1_wr_addr",   32'(bus.wr_addr_o),   32'd15);
    check("t1_done",      32'(bus.done_o),      32'd1);
    cyc();
    check("t1_wr_en_off", 32'(bus.wr_en_o),     32'd0);

    // Mask 0 with post 0: a single trigger sample at address 0.
    bus.trig_mask_i = 8'h00; bus.post_count_i = 8'd0;
    rearm();
    cyc();
    check("t2_trig_addr", 32'(bus.trig_addr_o), 32'd0);
    check("t2_wr_addr",   32'(bus.wr_addr_o),   32'd1);
    check("t2_wrapped",   32'(bus.wrapped_o),   32'd0);

    // No match for 300 cycles: the address wraps and the sequencer stays armed.
    bus.trig_mask_i = 8'hFF;
    rearm();
    repeat (300) cyc();
    check("t3_wrapped", 32'(bus.wrapped_o), 32'd1);
    check("t3_addr",    32'(bus.wr_addr_o), 32'd44);

    // CLEAR during the post-trigger phase, then a held ARM must not re-arm.
    bus.trig_mask_i = 8'h00; bus.post_count_i = 8'd6;
    rearm();
    cyc();
    repeat (3) cyc();
    bus.cmd_i = CLR; cyc();
    check("t4_cleared", 32'(bus.state_o), 32'd0);
    bus.post_count_i = 8'd0;
    bus.cmd_i = ARM; cyc(); cyc();
    repeat (5) cyc();
    check("t4_held_arm", 32'(bus.state_o), 32'd3);
    rearm();
    check("t4_rearm", 32'(bus.state_o), 32'd1);

    // Reset asserted together with an arm edge.
    bus.cmd_i = 32'h0; cyc();
    rst = 1'b1; bus.cmd_i = ARM; cyc();
    check("t5_rst_arm", 32'(bus.state_o), 32'd0);
    bus.cmd_i = 32'h0; cyc();
    rst = 1'b0; cyc();

`ifdef LOGTHIEF_TRIG_OCCUR_EN
    // Third match at address 20 fires.
    bus.occur_count_i = 8'd2; bus.trig_mask_i = 8'hFF; bus.trig_value_i = 8'hAA;
    bus.post_count_i = 8'd1;
    rearm();
    for (int a = 0; a < 24; a++) begin
      bus.trig_data_i = (a == 5 || a == 9 || a == 20) ? 8'hAA : 8'h00;
      cyc();
    end
    check("t6_occur_trig", 32'(bus.trig_addr_o), 32'd20);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0) begin
        pick = $urandom_range(0, 19);
        bus.cmd_i = (pick < 10) ? ARM : (pick < 15) ? 32'h0 : (pick < 17) ? CLR : $urandom;
      end
      if ($urandom_range(0, 99) == 0) begin
        pick = $urandom_range(0, 2);
        bus.trig_mask_i  = (pick == 0) ? 8'h00 : (pick == 1) ? 8'h07 : 8'($urandom);
        bus.trig_value_i = 8'($urandom_range(0, 7));
        bus.post_count_i = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 20));
`ifdef LOGTHIEF_TRIG_OCCUR_EN
        bus.occur_count_i = 8'($urandom_range(0, 3));
`endif
      end
      bus.trig_data_i = 8'($urandom_range(0, 7));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
